// File: rtl/rggen_apb_bridge_pkg.sv
// Shared types for the APB master bridge: FSM states and response status codes.
package rggen_apb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      ACCESS   = 2'd2,
      RESPONSE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      OKAY    = 2'b00,
      SLVERR  = 2'b10,
      TIMEOUT = 2'b11
   } status_e;

endpackage

// File: rtl/rggen_apb_master_bridge.sv
// Drives an external-register request onto an APB master port and returns
// data/status with a one-cycle done pulse; a PREADY watchdog aborts hung slaves.
module rggen_apb_master_bridge
   import rggen_apb_bridge_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_request,
   input  logic                     i_write,
   input  logic [ADDRESS_WIDTH-1:0] i_address,
   input  logic [DATA_WIDTH-1:0]    i_write_data,
   output logic                     o_done,
   output logic [DATA_WIDTH-1:0]    o_read_data,
   output logic [1:0]               o_status,
   output logic [ADDRESS_WIDTH-1:0] o_paddr,
   output logic                     o_psel,
   output logic                     o_penable,
   output logic                     o_pwrite,
   output logic [DATA_WIDTH-1:0]    o_pwdata,
   input  logic                     i_pready,
   input  logic [DATA_WIDTH-1:0]    i_prdata,
   input  logic                     i_pslverr
);

   localparam int TIMEOUT_WIDTH = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   state_e state;
   logic   timeout_hit;

   generate
      if (TIMEOUT_CYCLES != 0) begin : g_wdog
         logic [TIMEOUT_WIDTH-1:0] count;

         // Counts ACCESS cycles without PREADY; cleared whenever not waiting.
         always_ff @(posedge clk) begin
            if (!rst_n)
               count <= '0;
            else if (state == ACCESS && !i_pready)
               count <= count + TIMEOUT_WIDTH'(1);
            else
               count <= '0;
         end

         assign timeout_hit = (count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
      end else begin : g_no_wdog
         assign timeout_hit = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         o_psel      <= 1'b0;
         o_penable   <= 1'b0;
         o_pwrite    <= 1'b0;
         o_done      <= 1'b0;
         o_paddr     <= '0;
         o_pwdata    <= '0;
         o_read_data <= '0;
         o_status    <= OKAY;
      end else begin
         case (state)
            IDLE: begin
               o_done <= 1'b0;
               if (i_request) begin
                  o_pwrite <= i_write;
                  o_paddr  <= i_address;
                  o_pwdata <= i_write_data;
                  o_psel   <= 1'b1;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               o_penable <= 1'b1;
               state     <= ACCESS;
            end
            ACCESS: begin
               // PREADY takes priority over a watchdog expiry in the same cycle.
               if (i_pready) begin
                  o_psel      <= 1'b0;
                  o_penable   <= 1'b0;
                  o_read_data <= o_pwrite ? '0 : i_prdata;
                  o_status    <= i_pslverr ? SLVERR : OKAY;
                  o_done      <= 1'b1;
                  state       <= RESPONSE;
               end else if (timeout_hit) begin
                  o_psel      <= 1'b0;
                  o_penable   <= 1'b0;
                  o_read_data <= '0;
                  o_status    <= TIMEOUT;
                  o_done      <= 1'b1;
                  state       <= RESPONSE;
               end
            end
            RESPONSE: begin
               o_done <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rggen_apb_master_bridge.sv
// Directed bench: table of APB transactions plus hand sequences for back-to-back,
// reset during ACCESS and the disabled-watchdog variant.
module tb_rggen_apb_master_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_request, i_write, i_pready, i_pslverr;
   logic [7:0]  i_address;
   logic [31:0] i_write_data, i_prdata;

   logic        done16, psel16, pen16, pwr16;
   logic [31:0] rd16, pwd16;
   logic [1:0]  st16;
   logic [7:0]  pa16;
   logic        done0, psel0, pen0, pwr0;
   logic [31:0] rd0, pwd0;
   logic [1:0]  st0;
   logic [7:0]  pa0;

   logic        sel0;
   logic        m_done, m_psel, m_pen, m_pwr;
   logic [31:0] m_rd, m_pwd;
   logic [1:0]  m_st;
   logic [7:0]  m_pa;

   int nvec = 0;
   int nerr = 0;

   int          s_waits;
   logic [31:0] s_prdata;
   logic        s_err;
   int          acc;

   always #5 clk = ~clk;

   rggen_apb_master_bridge #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .i_request(i_request), .i_write(i_write),
      .i_address(i_address), .i_write_data(i_write_data), .o_done(done16),
      .o_read_data(rd16), .o_status(st16), .o_paddr(pa16), .o_psel(psel16),
      .o_penable(pen16), .o_pwrite(pwr16), .o_pwdata(pwd16), .i_pready(i_pready),
      .i_prdata(i_prdata), .i_pslverr(i_pslverr));

   rggen_apb_master_bridge #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .i_request(i_request), .i_write(i_write),
      .i_address(i_address), .i_write_data(i_write_data), .o_done(done0),
      .o_read_data(rd0), .o_status(st0), .o_paddr(pa0), .o_psel(psel0),
      .o_penable(pen0), .o_pwrite(pwr0), .o_pwdata(pwd0), .i_pready(i_pready),
      .i_prdata(i_prdata), .i_pslverr(i_pslverr));

   assign m_done = sel0 ? done0 : done16;
   assign m_psel = sel0 ? psel0 : psel16;
   assign m_pen  = sel0 ? pen0  : pen16;
   assign m_pwr  = sel0 ? pwr0  : pwr16;
   assign m_rd   = sel0 ? rd0   : rd16;
   assign m_pwd  = sel0 ? pwd0  : pwd16;
   assign m_st   = sel0 ? st0   : st16;
   assign m_pa   = sel0 ? pa0   : pa16;

   // APB slave: PREADY after s_waits wait states (-1 = never), PSLVERR only with PREADY.
   always @(posedge clk) begin
      #1;
      if (m_psel && m_pen) acc = acc + 1;
      else acc = 0;
      i_pready  = (s_waits >= 0) && (acc == s_waits + 1);
      i_prdata  = s_prdata;
      i_pslverr = i_pready ? s_err : 1'b0;
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
      logic        err;
      logic [31:0] exp_rd;
      logic [1:0]  exp_st;
      int          exp_lat;
      int          exp_pc;
   } vec_t;

   vec_t tbl[6];

   // One transaction: returns edges until done, PSEL cycle count and stability violations.
   task automatic do_txn(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                         input int waits, input logic [31:0] prd, input logic err,
                         input logic hold, input int limit,
                         output int lat, output int pc, output int bad,
                         output logic [31:0] rdata, output logic [1:0] st);
      @(negedge clk);
      s_waits = waits; s_prdata = prd; s_err = err;
      i_request = 1'b1; i_write = wr; i_address = a; i_write_data = wd;
      lat = 0; pc = 0; bad = 0; rdata = '0; st = '0;
      while (lat < limit) begin
         @(posedge clk); #2;
         lat++;
         if (m_psel) begin
            pc++;
            if (m_pa !== a || m_pwr !== wr || m_pwd !== wd) bad++;
         end
         if (m_done) break;
      end
      if (!m_done) begin
         nvec++; nerr++;
         $display("FAIL done_wait: no o_done within %0d cycles", limit);
      end
      rdata = m_rd;
      st    = m_st;
      if (!hold) i_request = 1'b0;
      @(posedge clk); #2;
      chk("done_single_pulse", {63'd0, m_done}, 64'd0);
   endtask

   int          lat, pc, bad, cnt;
   logic [31:0] rdata;
   logic [1:0]  st;

   initial begin
      tbl[0] = '{1'b0, 8'h84, 32'h0,         0,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 2'b00, 3,  2};
      tbl[1] = '{1'b1, 8'h90, 32'h1234_5678, 4,  32'hCAFE_F00D, 1'b0, 32'h0,         2'b00, 7,  6};
      tbl[2] = '{1'b0, 8'h10, 32'h0,         1,  32'h0BAD_C0DE, 1'b1, 32'h0BAD_C0DE, 2'b10, 4,  3};
      tbl[3] = '{1'b1, 8'h20, 32'hAAAA_5555, 0,  32'h0000_1111, 1'b1, 32'h0,         2'b10, 3,  2};
      tbl[4] = '{1'b0, 8'hFC, 32'h0,         -1, 32'h7777_7777, 1'b0, 32'h0,         2'b11, 18, 17};
      tbl[5] = '{1'b0, 8'h04, 32'h0,         15, 32'h5A5A_5A5A, 1'b0, 32'h5A5A_5A5A, 2'b00, 18, 17};

      sel0 = 1'b0; acc = 0; s_waits = -1; s_prdata = '0; s_err = 1'b0;
      i_pready = 1'b0; i_prdata = '0; i_pslverr = 1'b0;
      i_request = 1'b0; i_write = 1'b0; i_address = '0; i_write_data = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_psel",  {63'd0, psel16}, 64'd0);
      chk("rst_pen",   {63'd0, pen16},  64'd0);
      chk("rst_done",  {63'd0, done16}, 64'd0);
      chk("rst_pwrite",{63'd0, pwr16},  64'd0);
      chk("rst_status",{62'd0, st16},   64'd0);
      chk("rst_paddr", {56'd0, pa16},   64'd0);
      chk("rst_rdata", {32'd0, rd16},   64'd0);
      chk("rst_pwdata",{32'd0, pwd16},  64'd0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits, tbl[i].prdata,
                tbl[i].err, 1'b0, 40, lat, pc, bad, rdata, st);
         chk($sformatf("v%0d_latency", i),   64'(lat),   64'(tbl[i].exp_lat));
         chk($sformatf("v%0d_psel_cycles", i), 64'(pc),  64'(tbl[i].exp_pc));
         chk($sformatf("v%0d_stable", i),    64'(bad),   64'd0);
         chk($sformatf("v%0d_rdata", i),     {32'd0, rdata}, {32'd0, tbl[i].exp_rd});
         chk($sformatf("v%0d_status", i),    {62'd0, st},    {62'd0, tbl[i].exp_st});
      end

      // Back-to-back: request held through RESPONSE, exactly one IDLE cycle before next SETUP.
      do_txn(1'b0, 8'h30, 32'h0, 0, 32'h1357_9BDF, 1'b0, 1'b1, 40, lat, pc, bad, rdata, st);
      chk("b2b_first_rdata", {32'd0, rdata}, {32'd0, 32'h1357_9BDF});
      chk("b2b_idle_gap", {63'd0, psel16}, 64'd0);
      @(posedge clk); #2;
      chk("b2b_next_setup", {62'd0, psel16, pen16}, 64'd2);
      cnt = 0;
      while (!done16 && cnt < 20) begin @(posedge clk); #2; cnt++; end
      chk("b2b_second_done_cycles", 64'(cnt), 64'd2);
      chk("b2b_second_status", {62'd0, st16}, 64'd0);
      i_request = 1'b0;
      @(posedge clk); #2;

      // Reset asserted while in ACCESS.
      @(negedge clk);
      s_waits = -1; i_request = 1'b1; i_write = 1'b0; i_address = 8'h44;
      repeat (3) @(posedge clk);
      #2;
      chk("pre_rst_in_access", {62'd0, psel16, pen16}, 64'd3);
      @(negedge clk) begin rst_n = 1'b0; i_request = 1'b0; end
      @(posedge clk); #2;
      chk("rst_access_psel_pen", {62'd0, psel16, pen16}, 64'd0);
      chk("rst_access_done", {63'd0, done16}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      cnt = 0;
      repeat (4) begin @(posedge clk); #2; if (done16 || psel16) cnt++; end
      chk("post_rst_quiet", 64'(cnt), 64'd0);
      do_txn(1'b0, 8'h48, 32'h0, 2, 32'h2468_ACE0, 1'b0, 1'b0, 40, lat, pc, bad, rdata, st);
      chk("post_rst_rdata", {32'd0, rdata}, {32'd0, 32'h2468_ACE0});
      chk("post_rst_status", {62'd0, st}, 64'd0);
      chk("post_rst_latency", 64'(lat), 64'd5);

      // Watchdog disabled: 100 wait states, then PREADY completes normally.
      sel0 = 1'b1;
      do_txn(1'b0, 8'h88, 32'h0, 100, 32'hFEED_FACE, 1'b0, 1'b0, 200, lat, pc, bad, rdata, st);
      chk("nowd_latency", 64'(lat), 64'd103);
      chk("nowd_psel_cycles", 64'(pc), 64'd102);
      chk("nowd_rdata", {32'd0, rdata}, {32'd0, 32'hFEED_FACE});
      chk("nowd_status", {62'd0, st}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
